// File: rtl/decoder_scan_arbiter.sv
// Round-robin arbiter for 8 requesters that drives a 3-to-8 decoder via sel, qualified by gnt_vld.
// Define SCAN_ARB_TIMEOUT_EN to build the HOLD_MAX hold timer and make the timeout output live.
module decoder_scan_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       gnt_vld,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] sel_reg, sel_next;
    logic [2:0] last_reg, last_next;
    logic       gnt_vld_reg, gnt_vld_next;
    logic       busy_reg, busy_next;

    logic [7:0] rot_req;
    logic [2:0] win_off;
    logic [2:0] win_idx;
    logic       any_req;
    logic       hold_hit;
    logic       grant_end;

    generate
        if (HOLD_MAX < 2) begin : g_bad_hold
            $error("HOLD_MAX must be at least 2");
        end
    endgenerate

    // rot_req[0] is the requester right after the last grantee, so the lowest set bit wins.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[3'(last_reg + 3'(gi + 1))];
        end
    endgenerate

    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_off = 3'(i);
            end
        end
    end

    assign any_req = |req;
    assign win_idx = last_reg + win_off + 3'd1;

`ifdef SCAN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;

    assign hold_hit = (cnt_reg == CNT_W'(HOLD_MAX - 1));

    // A done or dropped request on the final cycle counts as a normal release, not a timeout.
    always_comb begin
        cnt_next     = '0;
        timeout_next = 1'b0;
        if (state_reg == GRANT && !grant_end) begin
            cnt_next = cnt_reg + 1'b1;
        end
        if (state_reg == GRANT && hold_hit && !done && req[sel_reg]) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout = timeout_reg;
`else
    assign hold_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign grant_end = done || !req[sel_reg] || hold_hit;

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        last_next    = last_reg;
        gnt_vld_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en && any_req) begin
                    state_next   = GRANT;
                    sel_next     = win_idx;
                    gnt_vld_next = 1'b1;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_next = RELEASE;
                    last_next  = sel_reg;
                end else begin
                    gnt_vld_next = 1'b1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            sel_reg     <= 3'd0;
            last_reg    <= 3'd7;
            gnt_vld_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            last_reg    <= last_next;
            gnt_vld_reg <= gnt_vld_next;
            busy_reg    <= busy_next;
        end
    end

    assign sel     = sel_reg;
    assign gnt_vld = gnt_vld_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_decoder_scan_arbiter.sv
// Directed bench for decoder_scan_arbiter: vector table for arbitration order, plus
// hand sequences for the hold timer, done/timeout coincidence and reset mid-grant.
module tb_decoder_scan_arbiter;

    localparam int HOLD = 16;
`ifdef SCAN_ARB_TIMEOUT_EN
    localparam int   EXP_LEN = HOLD;
    localparam logic EXP_TO  = 1'b1;
`else
    localparam int   EXP_LEN = 40;
    localparam logic EXP_TO  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       gnt_vld;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int n;

    decoder_scan_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt_vld (gnt_vld),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] req;
        logic       en;
        logic       done;
        logic [2:0] sel;
        logic       gnt;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl [0:31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // req, en, done -> sel, gnt_vld, busy, timeout (outputs after the edge)
        tbl[0]  = '{8'h05, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{8'h05, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{8'h05, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{8'h05, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h05, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{8'h05, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{8'h05, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{8'h05, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h05, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{8'h05, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{8'h05, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{8'h05, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{8'h05, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{8'h05, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{8'h05, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{8'h81, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{8'h81, 1'b1, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{8'h81, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{8'h81, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{8'h81, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[20] = '{8'h80, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{8'h02, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[24] = '{8'hFF, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[25] = '{8'hFF, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};
        tbl[26] = '{8'hFF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[27] = '{8'hFF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[28] = '{8'hFF, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[29] = '{8'hFF, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[30] = '{8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[31] = '{8'h00, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};

        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        step();
        step();
        check("reset_outputs", {sel, gnt_vld, busy, timeout}, {3'd0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        step();
        check("idle_after_reset", {sel, gnt_vld, busy, timeout}, {3'd0, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 32; i++) begin
            req  = tbl[i].req;
            en   = tbl[i].en;
            done = tbl[i].done;
            step();
            $display("row %0d req=%h en=%b done=%b -> sel=%0d gnt_vld=%b busy=%b timeout=%b",
                     i, req, en, done, sel, gnt_vld, busy, timeout);
            check($sformatf("row%0d", i), {sel, gnt_vld, busy, timeout},
                  {tbl[i].sel, tbl[i].gnt, tbl[i].busy, tbl[i].to});
        end
        done = 1'b0;

        // Hold timer: req[3] held with no done.
        req = 8'h08;
        step();
        check("hold_grant", {sel, gnt_vld}, {3'd3, 1'b1});
        n = 1;
        while (gnt_vld && n < 40) begin
            step();
            if (gnt_vld) n++;
        end
        $display("hold sequence: gnt_vld high for %0d cycles", n);
        check("hold_len", n, EXP_LEN);
        if (gnt_vld) begin
            done = 1'b1;
            step();
            done = 1'b0;
        end
        check("hold_release", {sel, gnt_vld, busy, timeout}, {3'd3, 1'b0, 1'b1, EXP_TO});
        req = 8'h28;
        step();
        check("hold_pulse_end", {gnt_vld, busy, timeout}, 3'b000);
        step();
        check("hold_next_grant", {sel, gnt_vld}, {3'd5, 1'b1});
        done = 1'b1;
        req  = 8'h00;
        step();
        check("hold_next_release", {gnt_vld, timeout}, 2'b00);
        done = 1'b0;
        step();
        check("hold_idle", {gnt_vld, busy}, 2'b00);

        // done lands on the same edge as the last allowed hold cycle.
        req = 8'h01;
        step();
        check("coin_grant", {sel, gnt_vld}, {3'd0, 1'b1});
        for (int i = 0; i < HOLD - 1; i++) begin
            step();
            check($sformatf("coin_hold%0d", i), gnt_vld, 1'b1);
        end
        done = 1'b1;
        step();
        $display("coincide: gnt_vld=%b busy=%b timeout=%b", gnt_vld, busy, timeout);
        check("coin_release", {gnt_vld, busy, timeout}, 3'b010);
        done = 1'b0;
        req  = 8'h00;
        step();
        check("coin_idle", {gnt_vld, busy, timeout}, 3'b000);

        // Reset in the middle of a grant clears the pointer as well as the outputs.
        req = 8'h0C;
        step();
        check("rst_seq_grant2", {sel, gnt_vld}, {3'd2, 1'b1});
        done = 1'b1;
        step();
        done = 1'b0;
        check("rst_seq_release2", gnt_vld, 1'b0);
        step();
        step();
        check("rst_seq_grant3", {sel, gnt_vld, busy}, {3'd3, 1'b1, 1'b1});
        step();
        rst = 1'b1;
        #2;
        $display("async reset: sel=%0d gnt_vld=%b busy=%b timeout=%b", sel, gnt_vld, busy, timeout);
        check("rst_async", {sel, gnt_vld, busy, timeout}, {3'd0, 1'b0, 1'b0, 1'b0});
        step();
        rst = 1'b0;
        step();
        check("rst_lowest_grant", {sel, gnt_vld, busy}, {3'd2, 1'b1, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
